fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_if.sv | 30 +++
 rtl/fifo_burst_reader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Handshake and data bundle between the burst reader, its upstream FIFO and the downstream sink.
interface fifo_burst_reader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6
);
    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic              abort;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    // Reader side: pops the FIFO and drives the output stream.
    modport master (
        input  start, burst_len, abort, fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, busy, done
    );

    // Environment side: control, FIFO and sink.
    modport slave (
        output start, burst_len, abort, fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Reads a requested number of words from a one-cycle-latency FIFO and streams
// them out over a valid/ready port through a two-entry skid buffer.
module fifo_burst_reader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_reader_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  issue_q, issue_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              inflight_q;

    logic              m_valid_c;
    logic              xfer_c;
    logic [1:0]        occ_c;
    logic              rd_en_c;
    logic              abort_hit_c;

    // Buffer occupancy net of the word leaving this cycle, so pops can sustain one word per cycle.
    always_comb begin
        m_valid_c   = (count_q != 2'd0);
        xfer_c      = m_valid_c && bus.m_ready;
        occ_c       = count_q + 2'(inflight_q) - 2'(xfer_c);
        rd_en_c     = (state_q == ST_READ) && !bus.fifo_empty &&
                      (issue_q != '0) && (occ_c < 2'd2);
        abort_hit_c = bus.abort && (state_q != ST_IDLE);
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len != '0) begin
                        state_d = ST_READ;
                        issue_d = bus.burst_len;
                        rem_d   = bus.burst_len;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rd_en_c) begin
                    issue_d = issue_q - LEN_W'(1);
                    if (issue_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (xfer_c && (rem_q != '0)) begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (xfer_c && (rem_q != '0)) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                issue_d = '0;
                rem_d   = '0;
            end
        endcase
        if (abort_hit_c) begin
            state_d = ST_IDLE;
            issue_d = '0;
            rem_d   = '0;
            done_d  = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            issue_q <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Skid buffer: captures FIFO data one cycle after each pop, releases in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else if (abort_hit_c) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= bus.fifo_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (xfer_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_q + 2'(inflight_q) - 2'(xfer_c);
            inflight_q <= rd_en_c;
        end
    end

    // Output decode.
    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_valid    = m_valid_c;
    assign bus.m_data     = mem_q[rd_ptr_q];
    assign bus.m_last     = m_valid_c && (rem_q == LEN_W'(1));
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;

endmodule
